// File: rtl/arc_fetch_pkg.sv
// Shared types and instruction-field constants for the instruction fetch unit.
// The branch decode helper lives here so fetch and target logic agree on the encoding.
package arc_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_ISSUE = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR  = 32'h0100_0000;

    localparam int          OP_MSB     = 31;
    localparam int          OP_LSB     = 30;
    localparam int          OP2_MSB    = 24;
    localparam int          OP2_LSB    = 22;
    localparam logic [1:0]  BRANCH_OP  = 2'b00;
    localparam logic [2:0]  BRANCH_OP2 = 3'b010;
    localparam int          DISP22_W   = 22;

    function automatic logic is_branch(input logic [31:0] instr);
        return (instr[OP_MSB:OP_LSB] == BRANCH_OP) && (instr[OP2_MSB:OP2_LSB] == BRANCH_OP2);
    endfunction

endpackage

// File: rtl/arc_branch_target.sv
// Next-PC computation: PC + sext(disp22) for a taken branch, PC + 1 otherwise.
// Purely combinational; arithmetic wraps modulo 2^DATAWIDTH_BUS.
module arc_branch_target
    import arc_fetch_pkg::*;
#(
    parameter int DATAWIDTH_BUS = 32
) (
    input  logic [DATAWIDTH_BUS-1:0] pc,
    input  logic [DATAWIDTH_BUS-1:0] ir,
    input  logic                     branch_taken,
    output logic [DATAWIDTH_BUS-1:0] next_pc
);

    localparam logic [DATAWIDTH_BUS-1:0] PC_STEP = DATAWIDTH_BUS'(1);

    logic [DATAWIDTH_BUS-1:0] disp_ext;
    logic                     take;

    assign disp_ext = {{(DATAWIDTH_BUS-DISP22_W){ir[DISP22_W-1]}}, ir[DISP22_W-1:0]};
    assign take     = is_branch(ir[31:0]) && branch_taken;
    assign next_pc  = take ? (pc + disp_ext) : (pc + PC_STEP);

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: fetches one word per PC, holds it in IR for decode,
// and redirects the PC on taken branches when decode accepts the instruction.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | one cycle after reset before the first memory request
// FETCH | read request at PC outstanding, waiting for memory ACK
// ISSUE | IR/PC_OutBus hold a valid instruction until decode takes it
module instruction_fetch
    import arc_fetch_pkg::*;
#(
    parameter int                     DATAWIDTH_BUS = 32,
    parameter logic [DATAWIDTH_BUS-1:0] RESET_PC    = 32'h0000_0000
) (
    input  logic                     INSTRUCTION_FETCH_CLOCK_50,
    input  logic                     INSTRUCTION_FETCH_ResetInHigh_In,
    output logic [DATAWIDTH_BUS-1:0] INSTRUCTION_FETCH_Address_OutBus,
    output logic                     INSTRUCTION_FETCH_RD_Out,
    input  logic [DATAWIDTH_BUS-1:0] INSTRUCTION_FETCH_Data_InBus,
    input  logic                     INSTRUCTION_FETCH_ACK_In,
    input  logic                     INSTRUCTION_FETCH_Stall_In,
    input  logic                     INSTRUCTION_FETCH_BranchTaken_In,
    output logic [DATAWIDTH_BUS-1:0] INSTRUCTION_FETCH_IR_OutBus,
    output logic [DATAWIDTH_BUS-1:0] INSTRUCTION_FETCH_PC_OutBus,
    output logic                     INSTRUCTION_FETCH_Valid_Out
);

    fetch_state_t             state;
    logic [DATAWIDTH_BUS-1:0] pc;
    logic [DATAWIDTH_BUS-1:0] next_pc;

    // Target is always relative to the held instruction's own address.
    arc_branch_target #(
        .DATAWIDTH_BUS (DATAWIDTH_BUS)
    ) u_branch_target (
        .pc           (INSTRUCTION_FETCH_PC_OutBus),
        .ir           (INSTRUCTION_FETCH_IR_OutBus),
        .branch_taken (INSTRUCTION_FETCH_BranchTaken_In),
        .next_pc      (next_pc)
    );

    always_ff @(posedge INSTRUCTION_FETCH_CLOCK_50 or posedge INSTRUCTION_FETCH_ResetInHigh_In) begin
        if (INSTRUCTION_FETCH_ResetInHigh_In) begin
            state                            <= ST_IDLE;
            pc                               <= RESET_PC;
            INSTRUCTION_FETCH_Address_OutBus <= RESET_PC;
            INSTRUCTION_FETCH_RD_Out         <= 1'b0;
            INSTRUCTION_FETCH_Valid_Out      <= 1'b0;
            INSTRUCTION_FETCH_IR_OutBus      <= DATAWIDTH_BUS'(NOP_INSTR);
            INSTRUCTION_FETCH_PC_OutBus      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state                            <= ST_FETCH;
                    INSTRUCTION_FETCH_Address_OutBus <= pc;
                    INSTRUCTION_FETCH_RD_Out         <= 1'b1;
                    INSTRUCTION_FETCH_Valid_Out      <= 1'b0;
                end
                ST_FETCH: begin
                    INSTRUCTION_FETCH_Address_OutBus <= pc;
                    if (INSTRUCTION_FETCH_ACK_In) begin
                        state                       <= ST_ISSUE;
                        INSTRUCTION_FETCH_IR_OutBus <= INSTRUCTION_FETCH_Data_InBus;
                        INSTRUCTION_FETCH_PC_OutBus <= pc;
                        INSTRUCTION_FETCH_RD_Out    <= 1'b0;
                        INSTRUCTION_FETCH_Valid_Out <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (!INSTRUCTION_FETCH_Stall_In) begin
                        state                            <= ST_FETCH;
                        pc                               <= next_pc;
                        INSTRUCTION_FETCH_Address_OutBus <= next_pc;
                        INSTRUCTION_FETCH_RD_Out         <= 1'b1;
                        INSTRUCTION_FETCH_Valid_Out      <= 1'b0;
                    end
                end
                default: begin
                    state                       <= ST_IDLE;
                    INSTRUCTION_FETCH_RD_Out    <= 1'b0;
                    INSTRUCTION_FETCH_Valid_Out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: a memory/decode driver pushes expected
// (pc, instruction) pairs, a monitor pops and compares them on every Valid cycle.
module tb_instruction_fetch;

    localparam int W = 32;
    localparam logic [31:0] NOP_WORD = 32'h0100_0000;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] addr, data, ir_out, pc_out;
    logic         rd, valid;
    logic         ack = 1'b0, stall = 1'b0, taken = 1'b0;

    logic [W-1:0] addr2, ir2, pc2;
    logic [W-1:0] data2 = NOP_WORD;
    logic         rd2, valid2;
    logic         ack2 = 1'b1, stall2 = 1'b0, taken2 = 1'b0;

    instruction_fetch #(.DATAWIDTH_BUS(W), .RESET_PC(32'h0000_0000)) dut (
        .INSTRUCTION_FETCH_CLOCK_50       (clk),
        .INSTRUCTION_FETCH_ResetInHigh_In (rst),
        .INSTRUCTION_FETCH_Address_OutBus (addr),
        .INSTRUCTION_FETCH_RD_Out         (rd),
        .INSTRUCTION_FETCH_Data_InBus     (data),
        .INSTRUCTION_FETCH_ACK_In         (ack),
        .INSTRUCTION_FETCH_Stall_In       (stall),
        .INSTRUCTION_FETCH_BranchTaken_In (taken),
        .INSTRUCTION_FETCH_IR_OutBus      (ir_out),
        .INSTRUCTION_FETCH_PC_OutBus      (pc_out),
        .INSTRUCTION_FETCH_Valid_Out      (valid)
    );

    instruction_fetch #(.DATAWIDTH_BUS(W), .RESET_PC(32'hFFFF_FFFF)) dut_wrap (
        .INSTRUCTION_FETCH_CLOCK_50       (clk),
        .INSTRUCTION_FETCH_ResetInHigh_In (rst),
        .INSTRUCTION_FETCH_Address_OutBus (addr2),
        .INSTRUCTION_FETCH_RD_Out         (rd2),
        .INSTRUCTION_FETCH_Data_InBus     (data2),
        .INSTRUCTION_FETCH_ACK_In         (ack2),
        .INSTRUCTION_FETCH_Stall_In       (stall2),
        .INSTRUCTION_FETCH_BranchTaken_In (taken2),
        .INSTRUCTION_FETCH_IR_OutBus      (ir2),
        .INSTRUCTION_FETCH_PC_OutBus      (pc2),
        .INSTRUCTION_FETCH_Valid_Out      (valid2)
    );

    always #5 clk = ~clk;

    int           checks = 0;
    int           errors = 0;
    logic [63:0]  exp_q[$];
    logic [31:0]  mem[64];
    logic [31:0]  pc_model = 32'h0;
    logic [31:0]  held_pc = 32'h0, held_ir = 32'h0;
    int           mode = 0;
    logic         take6 = 1'b0;
    int           accepted = 0;
    logic         prev_rd = 1'b0;
    logic         rd_started = 1'b0;
    int           wrap_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference next-PC from the instruction-set rules using plain integer arithmetic.
    function automatic logic [31:0] model_next(input logic [31:0] p, input logic [31:0] ir, input logic tk);
        int disp;
        if (ir[31:30] == 2'b00 && ir[24:22] == 3'b010 && tk) begin
            disp = int'(ir[21:0]);
            if (ir[21]) disp = disp - (1 << 22);
            return p + 32'(disp);
        end
        return p + 32'd1;
    endfunction

    task automatic drive_step();
        if (mode == 0) begin
            if (rd_started) check("rd_alternate", {31'b0, rd}, {31'b0, ~prev_rd});
            if (rd) rd_started = 1'b1;
            prev_rd = rd;
        end
        if (rd) begin
            check("fetch_addr", addr, pc_model);
            if (mode == 0)      ack = 1'b1;
            else if (mode == 2) ack = 1'b0;
            else                ack = ($urandom_range(0, 2) != 0);
            data = mem[addr[5:0]];
            if (ack) begin
                held_pc = pc_model;
                held_ir = mem[pc_model[5:0]];
                exp_q.push_back({held_pc, held_ir});
            end
        end else begin
            ack  = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            data = $urandom;
        end
        if (valid) begin
            if (mode == 1) begin
                stall = ($urandom_range(0, 2) == 0);
                taken = 1'($urandom_range(0, 1));
            end else begin
                stall = 1'b0;
                taken = (mode == 0) && take6 && (held_pc == 32'd6);
            end
            if (!stall) begin
                pc_model = model_next(held_pc, held_ir, taken);
                accepted++;
            end
        end else begin
            stall = 1'($urandom_range(0, 1));
            taken = 1'($urandom_range(0, 1));
        end
    endtask

    logic        prev_valid = 1'b0;
    logic [63:0] cur = 64'h0;

    always @(posedge clk) begin
        #1;
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (valid) begin
                if (!prev_valid) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_valid: got instruction %h with empty queue expected none", ir_out);
                    end else begin
                        cur = exp_q.pop_front();
                    end
                end
                check("ir_out", ir_out, cur[31:0]);
                check("pc_out", pc_out, cur[63:32]);
                check("rd_low_in_issue", {31'b0, rd}, 32'h0);
            end
            prev_valid = valid;
        end
    end

    always @(negedge clk) begin
        if (!rst && rd2 && wrap_seen < 2) begin
            check(wrap_seen == 0 ? "wrap_first_addr" : "wrap_next_addr", addr2,
                  wrap_seen == 0 ? 32'hFFFF_FFFF : 32'h0000_0000);
            wrap_seen++;
        end
    end

    initial begin
        logic [31:0] w;
        int          d;
        bit          found;
        for (int i = 0; i < 64; i++) begin
            w = $urandom;
            if (w[31:30] == 2'b00 && w[24:22] == 3'b010) w[22] = 1'b1;
            mem[i] = w;
            if (i >= 8 && $urandom_range(0, 2) == 0) begin
                d = int'($urandom_range(0, 16)) - 8;
                mem[i] = {2'b00, 5'($urandom), 3'b010, 22'(d)};
            end
        end
        mem[0] = 32'h9080_200A;
        mem[6] = 32'h12BF_FFFC;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("reset_rd", {31'b0, rd}, 32'h0);
        check("reset_valid", {31'b0, valid}, 32'h0);
        check("reset_ir", ir_out, NOP_WORD);
        check("reset_pc_out", pc_out, 32'h0);
        check("reset_addr", addr, 32'h0);
        check("reset_wrap_addr", addr2, 32'hFFFF_FFFF);
        @(negedge clk);
        rst = 1'b0;

        mode  = 0;
        take6 = 1'b1;
        repeat (16) begin @(negedge clk); drive_step(); end
        take6 = 1'b0;
        repeat (12) begin @(negedge clk); drive_step(); end

        mode = 1;
        repeat (600) begin @(negedge clk); drive_step(); end

        mode  = 2;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            drive_step();
            if (rd) found = 1'b1;
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL reach_fetch: got no RD within 40 cycles expected RD high");
        end
        repeat (2) begin @(negedge clk); drive_step(); end
        #2;
        rst = 1'b1;
        #1;
        check("midreset_rd", {31'b0, rd}, 32'h0);
        check("midreset_valid", {31'b0, valid}, 32'h0);
        check("midreset_ir", ir_out, NOP_WORD);
        check("midreset_pc_out", pc_out, 32'h0);
        check("midreset_addr", addr, 32'h0);
        exp_q.delete();
        pc_model = 32'h0;
        repeat (2) @(negedge clk);
        rst  = 1'b0;
        mode = 1;
        repeat (100) begin @(negedge clk); drive_step(); end

        checks++;
        if (accepted < 100) begin
            errors++;
            $display("FAIL progress: got %0d accepted instructions expected at least 100", accepted);
        end
        check("wrap_progress", 32'(wrap_seen), 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
